// File: rtl/lm_sm_sequencer.sv
// LM/SM multi-cycle sequencer: expands a base address plus register list into
// one data_memory access per set list bit, lowest register first, one per clock.
module lm_sm_sequencer #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned NREG   = 8,
  parameter int unsigned SEL_W  = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              is_store,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [NREG-1:0]   reg_list,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_write_n,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [SEL_W-1:0]  rf_rd_sel,
  input  logic [DATA_W-1:0] rf_rd_data,
  output logic              rf_wr_en,
  output logic [SEL_W-1:0]  rf_wr_sel,
  output logic [DATA_W-1:0] rf_wr_data
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_XFER = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [NREG-1:0]   pend_q, pend_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              op_q, op_d;

  logic [SEL_W-1:0]  idx;
  logic [NREG-1:0]   pend_clr;

  // Lowest set bit of the pending list selects the register for this cycle.
  always_comb begin
    idx = '0;
    for (int i = int'(NREG) - 1; i >= 0; i--) begin
      if (pend_q[i]) idx = SEL_W'(i);
    end
    pend_clr = pend_q & ~(NREG'(1) << idx);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      pend_q  <= '0;
      addr_q  <= '0;
      op_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      addr_q  <= addr_d;
      op_q    <= op_d;
    end
  end

  // Next-state and output decode; outputs only leave idle values in XFER/DONE.
  always_comb begin
    state_d     = state_q;
    pend_d      = pend_q;
    addr_d      = addr_q;
    op_d        = op_q;
    busy        = 1'b0;
    done        = 1'b0;
    mem_addr    = '0;
    mem_write_n = 1'b1;
    mem_wdata   = '0;
    rf_rd_sel   = '0;
    rf_wr_en    = 1'b0;
    rf_wr_sel   = '0;
    rf_wr_data  = '0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (reg_list != '0) begin
            pend_d  = reg_list;
            addr_d  = base_addr;
            op_d    = is_store;
            state_d = S_XFER;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_XFER: begin
        busy     = 1'b1;
        mem_addr = addr_q;
        if (op_q) begin
          rf_rd_sel   = idx;
          mem_wdata   = rf_rd_data;
          mem_write_n = 1'b0;
        end else begin
          rf_wr_en   = 1'b1;
          rf_wr_sel  = idx;
          rf_wr_data = mem_rdata;
        end
        pend_d = pend_clr;
        addr_d = addr_q + ADDR_W'(1);
        if (pend_clr == '0) state_d = S_DONE;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_lm_sm_sequencer.sv
// Directed bench for lm_sm_sequencer with behavioural data memory and register file.
module tb_lm_sm_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        is_store;
  logic [15:0] base_addr;
  logic [7:0]  reg_list;
  logic        busy, done, mem_write_n, rf_wr_en;
  logic [15:0] mem_addr, mem_wdata, mem_rdata, rf_rd_data, rf_wr_data;
  logic [2:0]  rf_rd_sel, rf_wr_sel;

  logic [15:0] mem [0:65535];
  logic [15:0] rf  [0:7];

  logic        mem_poke_en = 1'b0;
  logic [15:0] mem_poke_addr = '0;
  logic [15:0] mem_poke_data = '0;
  logic        rf_poke_en = 1'b0;
  logic [2:0]  rf_poke_sel = '0;
  logic [15:0] rf_poke_data = '0;

  int n_checks = 0;
  int n_fail   = 0;
  int wr_count = 0;
  int rfw_count = 0;
  int done_count = 0;
  int busy_count = 0;
  int wr0, rfw0, d0, b0;

  always #5 clk = ~clk;

  lm_sm_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .is_store(is_store),
    .base_addr(base_addr), .reg_list(reg_list), .busy(busy), .done(done),
    .mem_addr(mem_addr), .mem_write_n(mem_write_n), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .rf_rd_sel(rf_rd_sel), .rf_rd_data(rf_rd_data),
    .rf_wr_en(rf_wr_en), .rf_wr_sel(rf_wr_sel), .rf_wr_data(rf_wr_data)
  );

  assign mem_rdata  = mem[mem_addr];
  assign rf_rd_data = rf[rf_rd_sel];

  always @(posedge clk) begin
    if (!mem_write_n) mem[mem_addr] <= mem_wdata;
    else if (mem_poke_en) mem[mem_poke_addr] <= mem_poke_data;
  end

  always @(posedge clk) begin
    if (rf_wr_en) rf[rf_wr_sel] <= rf_wr_data;
    else if (rf_poke_en) rf[rf_poke_sel] <= rf_poke_data;
  end

  always @(posedge clk) begin
    if (!mem_write_n) wr_count <= wr_count + 1;
    if (rf_wr_en)     rfw_count <= rfw_count + 1;
    if (done)         done_count <= done_count + 1;
    if (busy)         busy_count <= busy_count + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_ctl"}, 32'({busy, done, mem_write_n, rf_wr_en}), 32'h2);
    check({tag, "_sel"}, 32'({rf_rd_sel, rf_wr_sel}), 32'h0);
    check({tag, "_addr"}, 32'(mem_addr), 32'h0);
    check({tag, "_data"}, 32'({mem_wdata, rf_wr_data}), 32'h0);
  endtask

  task automatic mem_poke(input logic [15:0] a, input logic [15:0] d);
    mem_poke_en = 1'b1; mem_poke_addr = a; mem_poke_data = d;
    @(negedge clk);
    mem_poke_en = 1'b0;
  endtask

  task automatic rf_poke(input logic [2:0] s, input logic [15:0] d);
    rf_poke_en = 1'b1; rf_poke_sel = s; rf_poke_data = d;
    @(negedge clk);
    rf_poke_en = 1'b0;
  endtask

  task automatic kick(input logic st, input logic [15:0] b, input logic [7:0] l);
    start = 1'b1; is_store = st; base_addr = b; reg_list = l;
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; is_store = 1'b0; base_addr = '0; reg_list = '0;
    repeat (2) @(negedge clk);
    check_idle("in_reset");
    reset = 1'b1;
    @(negedge clk);
    check_idle("post_reset");
    check("no_strobe_reset", 32'(wr_count), 32'd0);

    // SM of R1,R2 to 0x14/0x15
    rf_poke(3'd1, 16'h1111);
    rf_poke(3'd2, 16'h2222);
    b0 = busy_count;
    kick(1'b1, 16'h0014, 8'b0000_0110);
    check("sm_c1_ctl", 32'({busy, done, mem_write_n}), 32'h4);
    check("sm_c1_addr", 32'(mem_addr), 32'h0014);
    check("sm_c1_sel", 32'(rf_rd_sel), 32'd1);
    check("sm_c1_wdata", 32'(mem_wdata), 32'h1111);
    @(negedge clk);
    check("sm_c2_ctl", 32'({busy, done, mem_write_n}), 32'h4);
    check("sm_c2_addr", 32'(mem_addr), 32'h0015);
    check("sm_c2_wdata", 32'({13'd0, rf_rd_sel, mem_wdata}), 32'h0002_2222);
    @(negedge clk);
    check("sm_done", 32'({busy, done, mem_write_n}), 32'h3);
    @(negedge clk);
    check_idle("sm_after");
    check("sm_mem14", 32'(mem[16'h0014]), 32'h1111);
    check("sm_mem15", 32'(mem[16'h0015]), 32'h2222);
    check("sm_busy_cycles", 32'(busy_count - b0), 32'd2);

    // LM of R0,R7 from 0x17/0x18
    mem_poke(16'h0017, 16'h0010);
    mem_poke(16'h0018, 16'h0005);
    rfw0 = rfw_count;
    kick(1'b0, 16'h0017, 8'b1000_0001);
    check("lm_c1_ctl", 32'({busy, done, mem_write_n, rf_wr_en}), 32'hB);
    check("lm_c1", 32'({mem_addr, 13'd0, rf_wr_sel}), 32'h0017_0000);
    check("lm_c1_data", 32'(rf_wr_data), 32'h0010);
    @(negedge clk);
    check("lm_c2_ctl", 32'({busy, done, mem_write_n, rf_wr_en}), 32'hB);
    check("lm_c2", 32'({mem_addr, 13'd0, rf_wr_sel}), 32'h0018_0007);
    check("lm_c2_data", 32'(rf_wr_data), 32'h0005);
    @(negedge clk);
    check("lm_done", 32'({busy, done, rf_wr_en}), 32'h2);
    @(negedge clk);
    check_idle("lm_after");
    check("lm_r0", 32'(rf[0]), 32'h0010);
    check("lm_r7", 32'(rf[7]), 32'h0005);
    check("lm_wr_cycles", 32'(rfw_count - rfw0), 32'd2);

    // Empty list: straight to DONE
    wr0 = wr_count; b0 = busy_count;
    kick(1'b1, 16'h0030, 8'h00);
    check("empty_done", 32'({busy, done, mem_write_n}), 32'h3);
    @(negedge clk);
    check_idle("empty_after");
    check("empty_no_write", 32'(wr_count - wr0), 32'd0);
    check("empty_no_busy", 32'(busy_count - b0), 32'd0);

    // Address wrap 0xFFFF -> 0x0000
    rf_poke(3'd0, 16'hA0A0);
    rf_poke(3'd1, 16'hB1B1);
    kick(1'b1, 16'hFFFF, 8'h03);
    check("wrap_c1", 32'({mem_addr, mem_wdata}), 32'hFFFF_A0A0);
    @(negedge clk);
    check("wrap_c2", 32'({mem_addr, mem_wdata}), 32'h0000_B1B1);
    @(negedge clk);
    check("wrap_done", 32'({busy, done}), 32'h1);
    @(negedge clk);
    check("wrap_memffff", 32'(mem[16'hFFFF]), 32'hA0A0);
    check("wrap_mem0000", 32'(mem[16'h0000]), 32'hB1B1);

    // Full list, ignored restart, reset in 3rd XFER cycle
    for (int i = 0; i < 8; i++) rf_poke(3'(i), 16'h5000 + 16'(i));
    mem_poke(16'h0102, 16'h0000);
    mem_poke(16'h0200, 16'h0000);
    wr0 = wr_count; d0 = done_count;
    kick(1'b1, 16'h0100, 8'hFF);
    check("abort_c1_addr", 32'(mem_addr), 32'h0100);
    start = 1'b1; is_store = 1'b0; base_addr = 16'h0200; reg_list = 8'h01;
    @(negedge clk);
    start = 1'b0;
    check("restart_ignored", 32'({mem_addr, 15'd0, mem_write_n}), 32'h0101_0000);
    @(negedge clk);
    check("abort_c3", 32'({mem_addr, 15'd0, mem_write_n}), 32'h0102_0000);
    reset = 1'b0;
    #1;
    check("abort_strobe", 32'({busy, mem_write_n}), 32'h1);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_idle("abort_idle");
    repeat (3) @(negedge clk);
    check("abort_no_done", 32'(done_count - d0), 32'd0);
    check("abort_writes", 32'(wr_count - wr0), 32'd2);
    check("abort_mem100", 32'(mem[16'h0100]), 32'h5000);
    check("abort_mem101", 32'(mem[16'h0101]), 32'h5001);
    check("abort_mem102", 32'(mem[16'h0102]), 32'h0000);
    check("abort_mem200", 32'(mem[16'h0200]), 32'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
